cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 82 ++++++++
 tb/tb_cdb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin choice among functional-unit writeback
// requests, registered single-result broadcast on the CDB.
package cdb_arbiter_pkg;
    typedef struct packed {
        logic        is_valid;
        logic [5:0]  rob_tag;
        logic [31:0] result;
    } writeback_packet_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  writeback_packet_t fu_result [NUM_FU],
    output logic [NUM_FU-1:0] fu_cdb_gnt,
    input  logic              flush,
    output writeback_packet_t cdb
);
    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    writeback_packet_t cdb_q, cdb_d;
    logic [NUM_FU-1:0] gnt;
    logic              grant_any;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  cand;

    // Search rr_ptr, rr_ptr+1, ... modulo NUM_FU; sum stays below 2*NUM_FU,
    // so a single conditional subtract performs the wrap.
    always_comb begin
        gnt       = '0;
        grant_any = 1'b0;
        winner    = '0;
        sum       = '0;
        cand      = '0;
        if (rst && !flush) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                if (sum >= (PTR_W+1)'(NUM_FU)) begin
                    sum = sum - (PTR_W+1)'(NUM_FU);
                end
                cand = sum[PTR_W-1:0];
                if (!grant_any && fu_result[cand].is_valid) begin
                    grant_any = 1'b1;
                    winner    = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cdb_d    = '0;
        if (grant_any) begin
            cdb_d = fu_result[winner];
            if (winner == PTR_W'(NUM_FU - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign fu_cdb_gnt = gnt;
    assign cdb        = cdb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter (NUM_FU=4 plus a NUM_FU=1 instance).
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    writeback_packet_t fu_result [4];
    logic [3:0]        gnt;
    writeback_packet_t cdb;

    logic              flush1 = 1'b0;
    writeback_packet_t fu1_result [1];
    logic [0:0]        gnt1;
    writeback_packet_t cdb1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(4)) dut (
        .clk(clk), .rst(rst), .fu_result(fu_result),
        .fu_cdb_gnt(gnt), .flush(flush), .cdb(cdb)
    );

    cdb_arbiter #(.NUM_FU(1)) dut1 (
        .clk(clk), .rst(rst), .fu_result(fu1_result),
        .fu_cdb_gnt(gnt1), .flush(flush1), .cdb(cdb1)
    );

    typedef struct {
        logic       flush;
        logic [3:0] v;
        logic [3:0] gnt;
        int         win;
        logic [1:0] ptr;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic writeback_packet_t pkt(input int unsigned fu, input int unsigned s);
        writeback_packet_t p;
        p.is_valid = 1'b1;
        p.rob_tag  = 6'(fu);
        p.result   = 32'((s << 8) | fu);
        return p;
    endfunction

    task automatic drive(input logic [3:0] v, input int unsigned s);
        for (int unsigned i = 0; i < 4; i++) begin
            fu_result[i] = v[i] ? pkt(i, s) : '0;
        end
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic step_check(input string name, input logic [3:0] exp_gnt, input int win,
                              input int unsigned s, input logic [1:0] exp_ptr);
        writeback_packet_t exp_cdb;
        #1;
        chk({name, "_gnt"}, 64'(gnt), 64'(exp_gnt));
        exp_cdb = (win >= 0) ? pkt(int'(win), s) : '0;
        @(posedge clk);
        #1;
        chk({name, "_cdb"}, 64'(cdb), 64'(exp_cdb));
        chk({name, "_ptr"}, 64'(dut.rr_ptr_q), 64'(exp_ptr));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        drive(4'b0000, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b1001, 4'b1000, 3,  2'd0};
        tbl[1]  = '{1'b0, 4'b1001, 4'b0001, 0,  2'd1};
        tbl[2]  = '{1'b1, 4'b0010, 4'b0000, -1, 2'd1};
        tbl[3]  = '{1'b0, 4'b0010, 4'b0010, 1,  2'd2};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, -1, 2'd2};
        tbl[5]  = '{1'b0, 4'b0011, 4'b0001, 0,  2'd1};
        tbl[6]  = '{1'b0, 4'b0011, 4'b0010, 1,  2'd2};
        tbl[7]  = '{1'b0, 4'b1000, 4'b1000, 3,  2'd0};
        tbl[8]  = '{1'b1, 4'b0110, 4'b0000, -1, 2'd0};
        tbl[9]  = '{1'b0, 4'b0110, 4'b0010, 1,  2'd2};
        tbl[10] = '{1'b0, 4'b0110, 4'b0100, 2,  2'd3};
        tbl[11] = '{1'b0, 4'b0001, 4'b0001, 0,  2'd1};

        fu1_result[0] = '0;

        // Reset holds outputs low even with requests present.
        drive(4'b1111, 1);
        #2;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_cdb", 64'(cdb), 64'h0);
        chk("rst_ptr", 64'(dut.rr_ptr_q), 64'h0);
        do_reset();

        for (int unsigned k = 0; k < 5; k++) begin
            drive(4'b0000, 0);
            step_check("idle", 4'b0000, -1, 0, 2'd0);
        end

        // Single request from FU2 with result 0x0000000C.
        fu_result[0] = '0; fu_result[1] = '0; fu_result[3] = '0;
        fu_result[2] = '{is_valid: 1'b1, rob_tag: 6'd5, result: 32'h0000000C};
        #1;
        chk("fu2_gnt", 64'(gnt), 64'h4);
        @(posedge clk);
        #1;
        chk("fu2_result", 64'(cdb.result), 64'h0000000C);
        chk("fu2_valid", 64'(cdb.is_valid), 64'h1);
        chk("fu2_ptr", 64'(dut.rr_ptr_q), 64'h3);
        @(negedge clk);

        for (int unsigned k = 0; k < 12; k++) begin
            flush = tbl[k].flush;
            drive(tbl[k].v, 16 + k);
            step_check($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].win, 16 + k, tbl[k].ptr);
        end
        flush = 1'b0;

        // All four requesting continuously from reset.
        do_reset();
        for (int unsigned k = 0; k < 6; k++) begin
            drive(4'b1111, 40 + k);
            step_check($sformatf("rr%0d", k), 4'(1 << (k % 4)), int'(k % 4), 40 + k,
                       2'((k + 1) % 4));
        end

        // Reset between edges while a broadcast is live.
        do_reset();
        drive(4'b0110, 50);
        #1;
        chk("mid_gnt0", 64'(gnt), 64'h2);
        @(posedge clk);
        #1;
        chk("mid_valid", 64'(cdb.is_valid), 64'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(cdb.is_valid), 64'h0);
        chk("mid_rst_ptr", 64'(dut.rr_ptr_q), 64'h0);
        chk("mid_rst_gnt", 64'(gnt), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_after_gnt", 64'(gnt), 64'h2);
        drive(4'b0000, 0);

        // Single-FU instance.
        fu1_result[0] = pkt(0, 7);
        flush1 = 1'b1;
        #1;
        chk("one_flush_gnt", 64'(gnt1), 64'h0);
        @(posedge clk);
        #1;
        chk("one_flush_valid", 64'(cdb1.is_valid), 64'h0);
        @(negedge clk);
        flush1 = 1'b0;
        #1;
        chk("one_gnt", 64'(gnt1), 64'h1);
        @(posedge clk);
        #1;
        chk("one_cdb", 64'(cdb1), 64'(pkt(0, 7)));
        chk("one_ptr", 64'(dut1.rr_ptr_q), 64'h0);
        @(negedge clk);
        fu1_result[0] = '0;
        #1;
        chk("one_idle_gnt", 64'(gnt1), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
